// File: rtl/song_pkg.sv
// Shared types and defaults for the song progress counter.
package song_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } song_state_t;

  localparam int unsigned BEAT_W_DEFAULT = 8;

  localparam int unsigned SONG_LEN_DEFAULT = 42;
  localparam int unsigned SONG_LEN_SHORT   = 16;
  localparam int unsigned SONG_LEN_LONG    = 128;

endpackage

// File: rtl/beat_edge_detect.sv
// Turns the beat strobe into a per-clk tick, either on rising edges or on every high cycle.
module beat_edge_detect #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic beat_clk,
  output logic tick
);

  logic beat_q;

  // Cleared on reset so a strobe already high at release still counts as an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      beat_q <= 1'b0;
    end else begin
      beat_q <= beat_clk;
    end
  end

  assign tick = beat_clk & (EDGE_DET ? ~beat_q : 1'b1);

endmodule

// File: rtl/song_progress_counter.sv
// Counts beats through a song of latched length, with pause/abort/restart and progress quartile.
module song_progress_counter
  import song_pkg::*;
#(
  parameter int unsigned BEAT_W     = BEAT_W_DEFAULT,
  parameter bit          EDGE_DET   = 1'b1,
  parameter bit          AUTO_CLEAR = 1'b0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              beat_clk,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [BEAT_W-1:0] song_len,
  output logic [BEAT_W-1:0] beat_count,
  output logic              busy,
  output logic              paused,
  output logic              finish,
  output logic              done,
  output logic [1:0]        quarter
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_PAUSED = PAUSED;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam int unsigned QW = BEAT_W + 2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] count_q, count_d;
  logic [BEAT_W-1:0] len_q, len_d;
  logic              finish_q, finish_d;
  logic              tick;

  beat_edge_detect #(
    .EDGE_DET(EDGE_DET)
  ) u_beat_edge_detect (
    .clk     (clk),
    .n_rst   (n_rst),
    .beat_clk(beat_clk),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    finish_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      len_d   = song_len;
      count_d = '0;
      if (song_len == '0) begin
        state_d  = ST_DONE;
        finish_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          // Pause wins over a coincident tick, which is dropped.
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            count_d = count_q + 1'b1;
            if (count_d == len_q) begin
              state_d  = ST_DONE;
              finish_d = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (AUTO_CLEAR) begin
            state_d = ST_IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      len_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      finish_q <= finish_d;
    end
  end

  assign beat_count = count_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign paused     = (state_q == ST_PAUSED);
  assign done       = (state_q == ST_DONE);
  assign finish     = finish_q;

  // Two extra bits hold 4*count and 3*len without overflow.
  logic [QW-1:0] count_x4, len_x1, len_x2, len_x3;

  assign count_x4 = {count_q, 2'b00};
  assign len_x1   = QW'(len_q);
  assign len_x2   = {1'b0, len_q, 1'b0};
  assign len_x3   = len_x1 + len_x2;

  always_comb begin
    quarter = 2'd0;
    if (state_q == ST_DONE) begin
      quarter = 2'd3;
    end else if (state_q != ST_IDLE) begin
      if (count_x4 >= len_x3) begin
        quarter = 2'd3;
      end else if (count_x4 >= len_x2) begin
        quarter = 2'd2;
      end else if (count_x4 >= len_x1) begin
        quarter = 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_song_progress_counter.sv
// Runs three counter variants side by side against a per-cycle behavioural model.
module tb_song_progress_counter;

  localparam int unsigned BW = 8;
  localparam int NDUT = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          beat_clk, start, pause, abort;
  logic [BW-1:0] song_len;

  wire [NDUT-1:0][BW-1:0] cnt_w;
  wire [NDUT-1:0]         busy_w, paused_w, finish_w, done_w;
  wire [NDUT-1:0][1:0]    quarter_w;

  always #5 clk = ~clk;

  // dut0: edge mode, hold done; dut1: level mode, hold done; dut2: edge mode, auto-clear.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    song_progress_counter #(
      .BEAT_W    (BW),
      .EDGE_DET  (g != 1),
      .AUTO_CLEAR(g == 2)
    ) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .beat_clk  (beat_clk),
      .start     (start),
      .pause     (pause),
      .abort     (abort),
      .song_len  (song_len),
      .beat_count(cnt_w[g]),
      .busy      (busy_w[g]),
      .paused    (paused_w[g]),
      .finish    (finish_w[g]),
      .done      (done_w[g]),
      .quarter   (quarter_w[g])
    );
  end

  int m_st[NDUT], m_cnt[NDUT], m_len[NDUT];
  bit m_bq[NDUT], m_fin[NDUT];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit edge_mode(input int i);
    return i != 1;
  endfunction

  function automatic bit auto_clear(input int i);
    return i == 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_len[i] = 0; m_bq[i] = 0; m_fin[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      bit tk;
      tk = edge_mode(i) ? (beat_clk && !m_bq[i]) : beat_clk;
      m_bq[i]  = beat_clk;
      m_fin[i] = 0;
      if (abort) begin
        m_st[i] = M_IDLE; m_cnt[i] = 0;
      end else if (start) begin
        m_len[i] = song_len;
        m_cnt[i] = 0;
        if (song_len == 0) begin
          m_st[i] = M_DONE; m_fin[i] = 1;
        end else begin
          m_st[i] = M_RUN;
        end
      end else if (m_st[i] == M_RUN) begin
        if (pause) m_st[i] = M_PAUSED;
        else if (tk) begin
          m_cnt[i]++;
          if (m_cnt[i] == m_len[i]) begin
            m_st[i] = M_DONE; m_fin[i] = 1;
          end
        end
      end else if (m_st[i] == M_PAUSED) begin
        if (!pause) m_st[i] = M_RUN;
      end else if (m_st[i] == M_DONE && auto_clear(i)) begin
        m_st[i] = M_IDLE; m_cnt[i] = 0;
      end
    end
  endtask

  function automatic int exp_quarter(input int i);
    if (m_st[i] == M_IDLE) return 0;
    if (m_st[i] == M_DONE) return 3;
    for (int k = 3; k >= 1; k--) begin
      if (4 * m_cnt[i] >= k * m_len[i]) return k;
    end
    return 0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("dut%0d.count", i), cnt_w[i], m_cnt[i]);
      check_eq($sformatf("dut%0d.busy", i), busy_w[i],
               (m_st[i] == M_RUN || m_st[i] == M_PAUSED) ? 1 : 0);
      check_eq($sformatf("dut%0d.paused", i), paused_w[i], (m_st[i] == M_PAUSED) ? 1 : 0);
      check_eq($sformatf("dut%0d.done", i), done_w[i], (m_st[i] == M_DONE) ? 1 : 0);
      check_eq($sformatf("dut%0d.finish", i), finish_w[i], m_fin[i]);
      check_eq($sformatf("dut%0d.quarter", i), quarter_w[i], exp_quarter(i));
    end
  endtask

  task automatic step(input bit b, input bit s, input bit p, input bit a, input int len);
    beat_clk = b; start = s; pause = p; abort = a; song_len = BW'(len);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic beats(input int n, input bit p);
    repeat (n) begin
      step(1, 0, p, 0, 0);
      step(0, 0, p, 0, 0);
    end
  endtask

  int fin_seen, q1_at, q2_at, q3_at;
  bit rp;

  initial begin
    beat_clk = 0; start = 0; pause = 0; abort = 0; song_len = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #2;
    model_reset();
    check_all();
    #19 n_rst = 1'b1;

    // Basic run with quartile tracking.
    step(0, 1, 0, 0, 42);
    fin_seen = 0; q1_at = -1; q2_at = -1; q3_at = -1;
    repeat (42) begin
      step(1, 0, 0, 0, 0);
      if (finish_w[0]) fin_seen++;
      if (quarter_w[0] >= 1 && q1_at < 0) q1_at = cnt_w[0];
      if (quarter_w[0] >= 2 && q2_at < 0) q2_at = cnt_w[0];
      if (quarter_w[0] == 3 && q3_at < 0) q3_at = cnt_w[0];
      step(0, 0, 0, 0, 0);
      if (finish_w[0]) fin_seen++;
    end
    check_eq("basic.count", cnt_w[0], 42);
    check_eq("basic.done_hold", done_w[0], 1);
    check_eq("basic.finish_cycles", fin_seen, 1);
    check_eq("basic.q1_at", q1_at, 11);
    check_eq("basic.q2_at", q2_at, 21);
    check_eq("basic.q3_at", q3_at, 32);

    // Pause: tick coincident with pause is dropped, paused beats ignored.
    step(0, 1, 0, 0, 42);
    beats(10, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    beats(5, 1);
    step(0, 0, 0, 0, 0);
    check_eq("pause.count", cnt_w[0], 10);
    beats(32, 0);
    check_eq("pause.done", done_w[0], 1);

    // Held-high beat strobe.
    step(0, 1, 0, 0, 200);
    repeat (20) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("held.edge_count", cnt_w[0], 1);
    check_eq("held.level_count", cnt_w[1], 20);

    // Abort beats start; restart mid-song.
    step(0, 1, 0, 0, 100);
    beats(30, 0);
    step(0, 1, 0, 1, 50);
    check_eq("prio.count", cnt_w[0], 0);
    check_eq("prio.busy", busy_w[0], 0);
    step(0, 1, 0, 0, 100);
    beats(30, 0);
    step(0, 1, 0, 0, 8);
    check_eq("restart.count", cnt_w[0], 0);
    check_eq("restart.finish", finish_w[0], 0);
    beats(8, 0);
    check_eq("restart.done", done_w[0], 1);

    // Zero-length song.
    step(0, 1, 0, 0, 0);
    check_eq("len0.finish", finish_w[0], 1);
    step(0, 0, 0, 0, 0);
    check_eq("len0.finish_drop", finish_w[0], 0);

    // Auto-clear variant.
    step(0, 1, 0, 0, 3);
    step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("ac.done", done_w[2], 1);
    step(0, 0, 0, 0, 0);
    check_eq("ac.done_clear", done_w[2], 0);
    check_eq("ac.count_clear", cnt_w[2], 0);

    // Full-range song.
    step(0, 1, 0, 0, 255);
    beats(255, 0);
    check_eq("len255.count", cnt_w[0], 255);
    check_eq("len255.done", done_w[0], 1);

    // Asynchronous reset mid-count; no resume afterwards.
    step(0, 1, 0, 0, 42);
    beats(5, 0);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    n_rst = 1'b1;
    beats(4, 0);
    check_eq("rst.stays_idle", busy_w[0], 0);

    // Randomized traffic.
    rp = 0;
    repeat (3000) begin
      bit b, s, a;
      int len;
      b = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 149) == 0);
      a = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 14) == 0) rp = ~rp;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 30);
      step(b, s, rp, a, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
